// File: rtl/pipe_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package pipe_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: y = neg ? -x : x.
// Used both to take operand magnitudes and to restore result signs.
//   x   : value to correct
//   neg : negate when set
//   y   : corrected value
module muldiv_signfix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    always_comb begin
        y = neg ? (~x + W'(1)) : x;
    end

endmodule

// File: rtl/pipe_muldiv.sv
// Iterative MIPS mult/multu/div/divu unit owning HI/LO, one bit per cycle.
//   clk, clrn      : clock, async active-low reset
//   estart, eop    : E-stage muldiv instruction and its operation
//   ea, eb         : forwarded rs / rt operands
//   ehiwr, elowr   : E-stage mthi / mtlo (data is ea)
//   ehlrd          : E-stage mfhi / mflo
//   hi, lo         : HI/LO registers
//   busy           : registered state==BUSY
//   stall          : freeze PC, IF/ID and ID/EX this cycle
module pipe_muldiv
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned CNTW  = 5
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             estart,
    input  logic [1:0]       eop,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic             ehiwr,
    input  logic             elowr,
    input  logic             ehlrd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall
);

    localparam int unsigned W2 = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;       // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0] b_q, b_d;       // multiplier (shifted right), or divisor
    logic [W2-1:0]    acc_q, acc_d;   // product accumulator
    logic [WIDTH:0]   rem_q, rem_d;   // partial remainder
    logic             is_div_q, is_div_d;
    logic             neg_p_q, neg_p_d;   // product / quotient sign
    logic             neg_r_q, neg_r_d;   // remainder sign
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q;

    logic             op_signed;
    logic [WIDTH-1:0] ea_mag, eb_mag;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    acc_nxt;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_trial;
    logic             q_bit;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign op_signed = ~eop[0];

    muldiv_signfix #(.W(WIDTH)) u_abs_a (.x(ea), .neg(op_signed & ea[WIDTH-1]), .y(ea_mag));
    muldiv_signfix #(.W(WIDTH)) u_abs_b (.x(eb), .neg(op_signed & eb[WIDTH-1]), .y(eb_mag));
    muldiv_signfix #(.W(W2))    u_fix_p (.x(acc_nxt), .neg(neg_p_q), .y(prod_fix));
    muldiv_signfix #(.W(WIDTH)) u_fix_q (.x(quo_nxt), .neg(neg_p_q), .y(quo_fix));
    muldiv_signfix #(.W(WIDTH)) u_fix_r (.x(rem_nxt[WIDTH-1:0]), .neg(neg_r_q), .y(rem_fix));

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
        acc_nxt   = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {rem_q[WIDTH-1:0], a_q[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, b_q};
        q_bit     = ~div_trial[WIDTH+1];
        rem_nxt   = q_bit ? div_trial[WIDTH:0] : div_shift;
        quo_nxt   = {a_q[WIDTH-2:0], q_bit};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        is_div_d = is_div_q;
        neg_p_d  = neg_p_q;
        neg_r_d  = neg_r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE: begin
                if (estart) begin
                    a_d      = ea_mag;
                    b_d      = eb_mag;
                    acc_d    = '0;
                    rem_d    = '0;
                    cnt_d    = '0;
                    is_div_d = eop[1];
                    neg_p_d  = op_signed & (ea[WIDTH-1] ^ eb[WIDTH-1]);
                    neg_r_d  = op_signed & ea[WIDTH-1];
                    state_d  = S_BUSY;
                end else begin
                    if (ehiwr) hi_d = ea;
                    if (elowr) lo_d = ea;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + CNTW'(1);
                if (is_div_q) begin
                    rem_d = rem_nxt;
                    a_d   = quo_nxt;
                end else begin
                    acc_d = acc_nxt;
                    b_d   = b_q >> 1;
                end
                if (cnt_q == CNTW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    if (is_div_q) begin
                        // Divide by zero: quotient all ones; the corrected remainder is ea itself.
                        lo_d = (b_q == '0) ? '1 : quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (ehiwr) hi_d = ea;
                if (elowr) lo_d = ea;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            is_div_q <= 1'b0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            is_div_q <= is_div_d;
            neg_p_q  <= neg_p_d;
            neg_r_q  <= neg_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= (state_d == S_BUSY);
        end
    end

    // The muldiv itself is released in DONE; HI/LO accesses wait only while BUSY.
    assign stall = (estart & (state_q != S_DONE)) |
                   ((ehiwr | elowr | ehlrd) & (state_q == S_BUSY));
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_pipe_muldiv.sv
module tb_pipe_muldiv;
    import pipe_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         clrn;
    logic         estart, ehiwr, elowr, ehlrd;
    logic [1:0]   eop;
    logic [W-1:0] ea, eb;
    logic [W-1:0] hi, lo;
    logic         busy, stall;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    res_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_busy = 1'b0;

    pipe_muldiv #(.WIDTH(W), .CNTW(5)) dut (
        .clk(clk), .clrn(clrn), .estart(estart), .eop(eop), .ea(ea), .eb(eb),
        .ehiwr(ehiwr), .elowr(elowr), .ehlrd(ehlrd),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model straight from the MIPS rules, using wide integer arithmetic.
    function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t        r;
        longint      sa, sb, q, rm;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (op)
            OP_MULT:  begin p = 64'(sa * sb); r = {p[63:32], p[31:0]}; end
            OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; r = {p[63:32], p[31:0]}; end
            default: begin
                if (b == 0) begin
                    r.lo = '1;
                    r.hi = a;
                end else if (op == OP_DIV) begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r.lo = q[31:0];
                    r.hi = rm[31:0];
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: a DONE cycle is seen as busy falling; the result must match the queue head.
    always @(negedge clk) begin
        res_t e;
        if (!clrn) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                check("done_stall", 64'(stall), 64'(0));
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got hi=%h lo=%h want no result", hi, lo);
                end else begin
                    e = exp_q.pop_front();
                    check("res_hi", 64'(hi), 64'(e.hi));
                    check("res_lo", 64'(lo), 64'(e.lo));
                end
            end
            prev_busy = busy;
        end
    end

    // Full muldiv instruction held in E until released; stall length is checked.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        estart = 1'b1; eop = op; ea = a; eb = b;
        exp_q.push_back(model(op, a, b));
        #1;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("stall_len", 64'(n), 64'(W + 1));
        @(negedge clk);
        estart = 1'b0;
    endtask

    // Muldiv leaves E after IDLE cycle's start; a HI/LO access waits behind it.
    task automatic dep_access(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic hw, input logic rd, input logic [W-1:0] wdata);
        int n = 0;
        @(negedge clk);
        estart = 1'b1; eop = op; ea = a; eb = b;
        exp_q.push_back(model(op, a, b));
        #1;
        check("idle_stall", 64'(stall), 64'(1));
        @(negedge clk);
        estart = 1'b0; ehiwr = hw; ehlrd = rd; ea = wdata;
        #1;
        while (busy && n < 100) begin
            check("busy_stall", 64'(stall), 64'(1));
            n++;
            @(negedge clk);
            #1;
        end
        check("busy_len", 64'(n), 64'(W));
        @(negedge clk);
        ehiwr = 1'b0; ehlrd = 1'b0;
    endtask

    initial begin
        clrn = 1'b0; estart = 1'b0; eop = 2'b00; ea = '0; eb = '0;
        ehiwr = 1'b0; elowr = 1'b0; ehlrd = 1'b0;
        #12;
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        @(posedge clk); #3 clrn = 1'b1;

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(OP_MULT,  32'hFFFF_FFFD, 32'd5);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        issue(OP_DIVU,  32'd100,       32'd0);
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd0);

        // mthi and mtlo together in IDLE
        @(negedge clk);
        ehiwr = 1'b1; elowr = 1'b1; ea = 32'hA5A5_5A5A;
        @(negedge clk);
        ehiwr = 1'b0; elowr = 1'b0;
        #1;
        check("mtboth_hi", 64'(hi), 64'(32'hA5A5_5A5A));
        check("mtboth_lo", 64'(lo), 64'(32'hA5A5_5A5A));

        // mthi stalled behind multu 7*6, then applied in DONE
        dep_access(OP_MULTU, 32'd7, 32'd6, 1'b1, 1'b0, 32'h1234_5678);
        #1;
        check("mthi_hi", 64'(hi), 64'(32'h1234_5678));
        check("mthi_lo", 64'(lo), 64'(32'h0000_002A));

        // mflo stalled behind divu 100/7
        dep_access(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b1, 32'd0);
        ehlrd = 1'b1;
        #1;
        check("mflo_idle_stall", 64'(stall), 64'(0));
        @(negedge clk);
        ehlrd = 1'b0;

        // Reset in the middle of a divu
        @(negedge clk);
        estart = 1'b1; eop = OP_DIVU; ea = 32'd1000; eb = 32'd3;
        @(posedge clk);
        @(negedge clk);
        estart = 1'b0;
        repeat (10) @(posedge clk);
        #3 clrn = 1'b0;
        #1;
        check("abort_hi", 64'(hi), 64'(0));
        check("abort_lo", 64'(lo), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_stall", 64'(stall), 64'(0));
        @(negedge clk);
        @(posedge clk); #3 clrn = 1'b1;
        issue(OP_DIVU, 32'd9, 32'd4);

        for (int i = 0; i < 24; i++) begin
            issue(2'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd());
        end

        repeat (4) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
